// File: rtl/or_mask_splitter_if.sv
// Handshake bundle for or_mask_splitter: mask input side, per-bit beat output side,
// and the end-of-mask done pulse.
interface or_mask_splitter_if #(
    parameter int size = 8,
    parameter int idxw = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [size-1:0] in_mask;
    logic            out_valid;
    logic            out_ready;
    logic [idxw-1:0] out_idx;
    logic [size-1:0] out_onehot;
    logic            out_last;
    logic            done;

    modport master (
        output in_valid, in_mask, out_ready,
        input  in_ready, out_valid, out_idx, out_onehot, out_last, done
    );

    modport slave (
        input  in_valid, in_mask, out_ready,
        output in_ready, out_valid, out_idx, out_onehot, out_last, done
    );
endinterface

// File: rtl/or_mask_splitter.sv
// Splits a combined mask word into one beat per set bit, lowest index first,
// each beat carrying the bit index and its one-hot word.
//
// state | meaning
// IDLE  | ready for a new mask; done pulses here after a mask is consumed
// EMIT  | presenting the lowest set bit of residual until the last one is taken
module or_mask_splitter #(
    parameter int size = 8,
    parameter int idxw = 3
) (
    input logic               clk,
    input logic               rst,
    or_mask_splitter_if.slave bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state;
    logic [size-1:0] residual;
    logic [size-1:0] lowest;
    logic [idxw-1:0] lowest_idx;
    logic            single;
    logic            done_q;

    // Beat fields decode only from residual, so they stay put under backpressure.
    always_comb begin
        lowest     = residual & (~residual + 1'b1);
        single     = (residual != '0) && ((residual & (residual - 1'b1)) == '0);
        lowest_idx = '0;
        for (int i = 0; i < size; i++) begin
            if (lowest[i]) lowest_idx = idxw'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            residual <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        residual <= bus.in_mask;
                        if (bus.in_mask == '0) done_q <= 1'b1;
                        else                   state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        residual <= residual & ~lowest;
                        if (single) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == EMIT);
    assign bus.out_onehot = lowest;
    assign bus.out_idx    = lowest_idx;
    assign bus.out_last   = single;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_or_mask_splitter.sv
// Scoreboard bench for or_mask_splitter: directed masks push hand-computed beats and
// done pulses into a queue; a negedge monitor pops and compares on every handshake.
module tb_or_mask_splitter;
    localparam int size = 8;
    localparam int idxw = 3;

    typedef struct {
        logic            is_done;
        logic [idxw-1:0] idx;
        logic [size-1:0] onehot;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    or_mask_splitter_if #(.size(size), .idxw(idxw)) bus ();

    or_mask_splitter #(.size(size), .idxw(idxw)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic exp_beat(input int idx, input logic [size-1:0] oh, input logic last);
        exp_t e;
        e.is_done = 1'b0;
        e.idx     = idxw'(idx);
        e.onehot  = oh;
        e.last    = last;
        exp_q.push_back(e);
    endtask

    task automatic exp_done();
        exp_t e;
        e.is_done = 1'b1;
        e.idx     = '0;
        e.onehot  = '0;
        e.last    = 1'b0;
        exp_q.push_back(e);
    endtask

    // Present a mask and hold it until accepted; waits counts rejected cycles.
    task automatic send_mask(input logic [size-1:0] m, output int waits);
        waits        = 0;
        bus.in_valid = 1'b1;
        bus.in_mask  = m;
        while (!bus.in_ready && waits < 100) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!bus.in_ready) begin
            failures++;
            $display("FAIL accept_timeout mask=%0h", m);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    failures++;
                    $display("FAIL unexpected_beat idx=%0d onehot=%0h", bus.out_idx, bus.out_onehot);
                end else begin
                    if (bus.out_idx !== exp_q[0].idx || bus.out_onehot !== exp_q[0].onehot
                        || bus.out_last !== exp_q[0].last) begin
                        failures++;
                        $display("FAIL beat actual idx=%0d onehot=%0h last=%0b required idx=%0d onehot=%0h last=%0b",
                                 bus.out_idx, bus.out_onehot, bus.out_last,
                                 exp_q[0].idx, exp_q[0].onehot, exp_q[0].last);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (bus.done) begin
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int w;
        bus.in_valid  = 1'b0;
        bus.in_mask   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_onehot", bus.out_onehot, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: A4 -> idx 2,5,7
        exp_beat(2, 8'h04, 0); exp_beat(5, 8'h20, 0); exp_beat(7, 8'h80, 1); exp_done();
        send_mask(8'hA4, w);
        check("t1_first_beat_valid", bus.out_valid, 1);
        check("t1_in_ready_low", bus.in_ready, 0);
        drain("t1");

        // 2: A4 with first beat stalled 3 cycles
        bus.out_ready = 1'b0;
        exp_beat(2, 8'h04, 0); exp_beat(5, 8'h20, 0); exp_beat(7, 8'h80, 1); exp_done();
        send_mask(8'hA4, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold_valid", bus.out_valid, 1);
            check("t2_hold_idx", bus.out_idx, 2);
            check("t2_hold_onehot", bus.out_onehot, 8'h04);
            check("t2_hold_last", bus.out_last, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drain("t2");

        // 3: zero mask
        exp_done();
        send_mask(8'h00, w);
        check("t3_done", bus.done, 1);
        check("t3_out_valid", bus.out_valid, 0);
        check("t3_in_ready", bus.in_ready, 1);
        drain("t3");

        // 4: FF then 01 presented immediately; 01 waits out the 8 beats
        for (int i = 0; i < 8; i++) exp_beat(i, 8'(1 << i), (i == 7));
        exp_done();
        exp_beat(0, 8'h01, 1);
        exp_done();
        send_mask(8'hFF, w);
        send_mask(8'h01, w);
        check("t4_second_accept_wait", w, 8);
        drain("t4");

        // 5: reset during EMIT of F0 after one beat
        exp_beat(4, 8'h10, 0);
        send_mask(8'hF0, w);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_in_ready", bus.in_ready, 1);
        check("t5_done", bus.done, 0);
        check("t5_onehot_cleared", bus.out_onehot, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("t5_pending", exp_q.size(), 0);
        exp_beat(1, 8'h02, 1); exp_done();
        send_mask(8'h02, w);
        drain("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
